jtag_tap_controller: RTL and testbench

- IEEE 1149.1-style TAP controller that sequences the JTAG data registers: the 32-bit IDCODE chain, an internal 1-bit BYPASS, and an optional USER chain.
- Runs the 16-state TAP FSM, holds the instruction register, and decodes the active instruction into select lines.
- Generates capture/shift/update strobes and DR clock-enables for the chains, and muxes TDO.
- Sits between the USB-to-JTAG bridge pins (tck/tms/tdi/tdo) and the register chains.

---
 rtl/jtag_tap_controller.sv | 182 ++++++++++++++++++
 tb/tb_jtag_tap_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, DR select decode, TDO mux.
// Latency: state/IR/bypass update on rising tck; strobes, selects, clk_dr_en, tdo, tdo_en are zero-latency decodes.
// Backpressure: none; the FSM follows tms every tck and attached chains must act on every enabled edge.
// Optional feature macro: JTAG_USER_DR_EN adds the USER chain select and its tdo path.

module jtag_tap_controller #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = '1,
  parameter logic [IR_WIDTH-1:0] USER_INSTR   = IR_WIDTH'(8)
) (
  input  logic                tck,
  input  logic                rst,
  input  logic                tms,
  input  logic                tdi,
  input  logic                idcode_tdo,
  input  logic                user_tdo,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic                sel_idcode,
  output logic                sel_bypass,
  output logic                sel_user,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                clk_dr_en,
  output logic                tdo,
  output logic                tdo_en
);

  // State codes follow the 1149.1 reference encoding so tap_state is meaningful to debug tools.
  typedef enum logic [3:0] {
    S_TLR      = 4'hF,
    S_RTI      = 4'hC,
    S_SEL_DR   = 4'h7,
    S_CAP_DR   = 4'h6,
    S_SH_DR    = 4'h2,
    S_EX1_DR   = 4'h1,
    S_PAUSE_DR = 4'h3,
    S_EX2_DR   = 4'h0,
    S_UPD_DR   = 4'h5,
    S_SEL_IR   = 4'h4,
    S_CAP_IR   = 4'hE,
    S_SH_IR    = 4'hA,
    S_EX1_IR   = 4'h9,
    S_PAUSE_IR = 4'hB,
    S_EX2_IR   = 4'h8,
    S_UPD_IR   = 4'hD
  } tap_state_t;

`ifdef JTAG_USER_DR_EN
  localparam bit LP_USER_EN = 1'b1;
`else
  localparam bit LP_USER_EN = 1'b0;
`endif

  // Value loaded into the IR shift register in Capture-IR: the mandatory ...01 pattern.
  localparam logic [IR_WIDTH-1:0] LP_IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  tap_state_t          r_state;
  tap_state_t          w_state_nxt;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_ir_q;
  logic                r_bypass_q;

  logic w_cap_dr;
  logic w_sh_dr;
  logic w_upd_dr;
  logic w_cap_ir;
  logic w_sh_ir;
  logic w_upd_ir;
  logic w_sel_idcode;
  logic w_sel_user;
  logic w_sel_bypass;
  logic w_tdo;

  // State register; reset overrides tms.
  always_ff @(posedge tck) begin
    if (rst) begin
      r_state <= S_TLR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the 16-state TAP graph.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_TLR:      w_state_nxt = tms ? S_TLR    : S_RTI;
      S_RTI:      w_state_nxt = tms ? S_SEL_DR : S_RTI;
      S_SEL_DR:   w_state_nxt = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR:   w_state_nxt = tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:    w_state_nxt = tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR:   w_state_nxt = tms ? S_UPD_DR : S_PAUSE_DR;
      S_PAUSE_DR: w_state_nxt = tms ? S_EX2_DR : S_PAUSE_DR;
      S_EX2_DR:   w_state_nxt = tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR:   w_state_nxt = tms ? S_SEL_DR : S_RTI;
      S_SEL_IR:   w_state_nxt = tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR:   w_state_nxt = tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:    w_state_nxt = tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR:   w_state_nxt = tms ? S_UPD_IR : S_PAUSE_IR;
      S_PAUSE_IR: w_state_nxt = tms ? S_EX2_IR : S_PAUSE_IR;
      S_EX2_IR:   w_state_nxt = tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR:   w_state_nxt = tms ? S_SEL_DR : S_RTI;
      default:    w_state_nxt = S_TLR;
    endcase
  end

  assign w_cap_dr = (r_state == S_CAP_DR);
  assign w_sh_dr  = (r_state == S_SH_DR);
  assign w_upd_dr = (r_state == S_UPD_DR);
  assign w_cap_ir = (r_state == S_CAP_IR);
  assign w_sh_ir  = (r_state == S_SH_IR);
  assign w_upd_ir = (r_state == S_UPD_IR);

  // Instruction register: capture/shift the IR chain, commit on leaving Update-IR.
  // ir_q is forced to IDCODE on the edge that enters TLR so it is already valid while in TLR.
  always_ff @(posedge tck) begin
    if (rst) begin
      r_ir_sr <= '0;
      r_ir_q  <= IDCODE_INSTR;
    end else begin
      if (w_cap_ir) begin
        r_ir_sr <= LP_IR_CAPTURE;
      end else if (w_sh_ir) begin
        r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
      end
      if (w_state_nxt == S_TLR) begin
        r_ir_q <= IDCODE_INSTR;
      end else if (w_upd_ir) begin
        r_ir_q <= r_ir_sr;
      end
    end
  end

  // One-bit BYPASS register: cleared in Capture-DR, follows tdi in Shift-DR.
  always_ff @(posedge tck) begin
    if (rst) begin
      r_bypass_q <= 1'b0;
    end else if (w_cap_dr) begin
      r_bypass_q <= 1'b0;
    end else if (w_sh_dr) begin
      r_bypass_q <= tdi;
    end
  end

  // Instruction decode: anything that is not IDCODE or an enabled USER opcode is BYPASS.
  assign w_sel_idcode = (r_ir_q == IDCODE_INSTR);
  assign w_sel_user   = LP_USER_EN && (r_ir_q == USER_INSTR) && !w_sel_idcode;
  assign w_sel_bypass = (r_ir_q == BYPASS_INSTR) || !(w_sel_idcode || w_sel_user);

  // TDO mux: IR LSB in Shift-IR, selected chain in Shift-DR, quiet elsewhere.
  always_comb begin
    w_tdo = 1'b0;
    if (w_sh_ir) begin
      w_tdo = r_ir_sr[0];
    end else if (w_sh_dr) begin
      if (w_sel_idcode) begin
        w_tdo = idcode_tdo;
      end else if (w_sel_user) begin
        w_tdo = user_tdo;
      end else begin
        w_tdo = r_bypass_q;
      end
    end
  end

  assign tap_state  = r_state;
  assign ir_q       = r_ir_q;
  assign sel_idcode = w_sel_idcode;
  assign sel_user   = w_sel_user;
  assign sel_bypass = w_sel_bypass;
  assign capture_dr = w_cap_dr;
  assign shift_dr   = w_sh_dr;
  assign update_dr  = w_upd_dr;
  // Chains capture (shift_dr=0) or shift (shift_dr=1) only when enabled; Pause/Exit hold contents.
  assign clk_dr_en  = (w_cap_dr || w_sh_dr) && !w_sel_bypass;
  assign tdo        = w_tdo;
  assign tdo_en     = w_sh_dr || w_sh_ir;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Scoreboard bench for jtag_tap_controller: driver issues tms/tdi/rst and queues model-predicted outputs.
// Monitor pops one expectation per tck, sampled mid-low-phase, and compares every output.
// The bench also plays the IDCODE chain (32'h0000_0001) and a random USER chain source.

module tb_jtag_tap_controller;

  localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SDR = 4'h7, CDR = 4'h6, SHDR = 4'h2, E1DR = 4'h1,
                         PDR = 4'h3, E2DR = 4'h0, UDR = 4'h5, SIR = 4'h4, CIR = 4'hE, SHIR = 4'hA,
                         E1IR = 4'h9, PIR = 4'hB, E2IR = 4'h8, UIR = 4'hD;
  localparam logic [31:0] IDCODE_VAL = 32'h0000_0001;
`ifdef JTAG_USER_DR_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] ir;
    logic [2:0] sel;   // {idcode, bypass, user}
    logic [2:0] strb;  // {capture, shift, update}
    logic       cen;
    logic       tdo;
    logic       en;
  } exp_t;

  logic tck = 1'b0;
  always #5 tck = ~tck;

  logic       rst, tms, tdi, idcode_tdo, user_tdo;
  logic [3:0] tap_state, ir_q;
  logic       sel_idcode, sel_bypass, sel_user;
  logic       capture_dr, shift_dr, update_dr, clk_dr_en, tdo, tdo_en;

  jtag_tap_controller dut (
    .tck(tck), .rst(rst), .tms(tms), .tdi(tdi),
    .idcode_tdo(idcode_tdo), .user_tdo(user_tdo),
    .tap_state(tap_state), .ir_q(ir_q),
    .sel_idcode(sel_idcode), .sel_bypass(sel_bypass), .sel_user(sel_user),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .clk_dr_en(clk_dr_en), .tdo(tdo), .tdo_en(tdo_en)
  );

  // Reference model state
  logic [3:0]  nxt0 [16];
  logic [3:0]  nxt1 [16];
  logic [3:0]  m_state, m_ir_q, m_ir_sr;
  logic        m_byp;
  logic [31:0] m_chain;
  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic edge_def(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  function automatic exp_t predict(input logic u_tdo);
    exp_t e;
    logic is_id, is_us, is_by, in_shdr, in_shir, in_cdr;
    is_id   = (m_ir_q == 4'h1);
    is_us   = USER_EN && (m_ir_q == 4'h8);
    is_by   = !(is_id || is_us);
    in_shdr = (m_state == SHDR);
    in_shir = (m_state == SHIR);
    in_cdr  = (m_state == CDR);
    e.st    = m_state;
    e.ir    = m_ir_q;
    e.sel   = {is_id, is_by, is_us};
    e.strb  = {in_cdr, in_shdr, m_state == UDR};
    e.cen   = (in_cdr || in_shdr) && !is_by;
    if (in_shir)      e.tdo = m_ir_sr[0];
    else if (in_shdr) e.tdo = is_id ? m_chain[0] : (is_us ? u_tdo : m_byp);
    else              e.tdo = 1'b0;
    e.en    = in_shdr || in_shir;
    return e;
  endfunction

  task automatic model_step(input logic r, input logic m, input logic d);
    logic [3:0] ns;
    logic is_id;
    is_id = (m_ir_q == 4'h1);
    // The IDCODE chain is external and reacts to the pre-edge state, reset or not.
    if (is_id && m_state == CDR)  m_chain = IDCODE_VAL;
    if (is_id && m_state == SHDR) m_chain = (m_chain >> 1) | (d ? 32'h8000_0000 : 32'h0);
    if (r) begin
      m_state = TLR;
      m_ir_q  = 4'h1;
      m_ir_sr = 4'h0;
      m_byp   = 1'b0;
    end else begin
      ns = m ? nxt1[m_state] : nxt0[m_state];
      if (m_state == CDR)  m_byp = 1'b0;
      if (m_state == SHDR) m_byp = d;
      if (m_state == UIR)  m_ir_q = m_ir_sr;
      if (m_state == CIR)  m_ir_sr = 4'h1;
      if (m_state == SHIR) m_ir_sr = (m_ir_sr >> 1) | (d ? 4'h8 : 4'h0);
      if (ns == TLR)       m_ir_q = 4'h1;
      m_state = ns;
    end
  endtask

  // One tck: drive inputs in the low phase, queue the expected outputs, advance the model.
  task automatic cyc(input logic r, input logic m, input logic d);
    exp_t e;
    @(negedge tck);
    rst        = r;
    tms        = m;
    tdi        = d;
    idcode_tdo = m_chain[0];
    user_tdo   = 1'($urandom % 2);
    e = predict(user_tdo);
    exp_q.push_back(e);
    model_step(r, m, d);
  endtask

  task automatic go_rti();
    repeat (5) cyc(1'b0, 1'b1, 1'($urandom % 2));
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] v);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, i == 3, v[i]);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_dr_bits(input int n, input logic [63:0] data);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) cyc(1'b0, i == n - 1, data[i]);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
  endtask

  // Monitor: one expectation per cycle, sampled 2 time units after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge tck);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tap_state", {4'h0, tap_state}, {4'h0, e.st});
        chk("ir_q", {4'h0, ir_q}, {4'h0, e.ir});
        chk("selects", {5'h0, sel_idcode, sel_bypass, sel_user}, {5'h0, e.sel});
        chk("strobes", {5'h0, capture_dr, shift_dr, update_dr}, {5'h0, e.strb});
        chk("clk_dr_en", {7'h0, clk_dr_en}, {7'h0, e.cen});
        chk("tdo", {7'h0, tdo}, {7'h0, e.tdo});
        chk("tdo_en", {7'h0, tdo_en}, {7'h0, e.en});
      end
    end
  end

  // Driver
  initial begin
    edge_def(TLR, RTI, TLR);   edge_def(RTI, RTI, SDR);   edge_def(SDR, CDR, SIR);
    edge_def(CDR, SHDR, E1DR); edge_def(SHDR, SHDR, E1DR); edge_def(E1DR, PDR, UDR);
    edge_def(PDR, PDR, E2DR);  edge_def(E2DR, SHDR, UDR); edge_def(UDR, RTI, SDR);
    edge_def(SIR, CIR, TLR);   edge_def(CIR, SHIR, E1IR); edge_def(SHIR, SHIR, E1IR);
    edge_def(E1IR, PIR, UIR);  edge_def(PIR, PIR, E2IR);  edge_def(E2IR, SHIR, UIR);
    edge_def(UIR, RTI, SDR);

    rst = 1'b1; tms = 1'b0; tdi = 1'b0; idcode_tdo = 1'b0; user_tdo = 1'b0;
    @(posedge tck);
    m_state = TLR; m_ir_q = 4'h1; m_ir_sr = 4'h0; m_byp = 1'b0; m_chain = IDCODE_VAL;

    // Reset state, then tms=0 into Run-Test/Idle
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    // IDCODE read: 32 shifts
    shift_dr_bits(32, 64'h0);
    // Load BYPASS, then shift 8'hA5 through it
    load_ir(4'hF);
    shift_dr_bits(8, 64'hA5);
    // Undefined opcode falls to BYPASS, then five tms=1 from Shift-DR reach TLR
    load_ir(4'h3);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    // Reset in the middle of an IR shift of 4'h8
    load_ir(4'hF);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    // Full USER load and a DR shift through whatever it selects
    load_ir(4'h8);
    shift_dr_bits(12, 64'hABC);
    // Pause/Exit2 path through DR with IDCODE selected
    go_rti();
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);

    // Randomized phase
    for (int k = 0; k < 80; k++) begin
      case ($urandom % 4)
        0: begin
          go_rti();
          load_ir(($urandom % 2) ? 4'h1 : 4'($urandom_range(0, 15)));
        end
        1: begin
          go_rti();
          shift_dr_bits(int'($urandom_range(1, 40)), {$urandom, $urandom});
        end
        2: repeat (25) cyc(1'(($urandom % 120) == 0), 1'(($urandom % 3) == 0), 1'($urandom % 2));
        default: go_rti();
      endcase
    end

    // Let the monitor drain the scoreboard, bounded
    repeat (4) @(negedge tck);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
